baud_tick_gen_frac: RTL

Parametrised fractional baud-tick generator for the UART peripheral. It divides the system clock by a runtime-programmable integer-plus-fraction divisor and produces a one-cycle oversampling tick. From that tick it derives a bit-rate tick and a mid-bit sample tick. It replaces the fixed integer prescaler tick source. TX and RX share one instance, or each gets its own. RX uses `sync_clr` to phase-align to a start-bit edge.

---
 rtl/baud_tick_gen_frac.sv | 96 +++++++++
 1 files changed

// File: rtl/baud_tick_gen_frac.sv
// baud_tick_gen_frac: fractional clock divider producing oversample, bit and mid-bit ticks
//   clk, reset_n        : clock, asynchronous active-low reset
//   en                  : run enable; low freezes counters and silences ticks
//   div_int, div_frac   : divisor (integer clocks + fraction in 2^-FRAC_W units)
//   load                : captures div_int/div_frac into the pending divisor
//   sync_clr            : restarts the phase and applies any pending divisor
//   tick_os/bit/mid     : one-cycle registered ticks
//   cfg_err             : active integer divisor is zero
module baud_tick_gen_frac #(
    parameter int CNT_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [CNT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              load,
    input  logic              sync_clr,
    output logic              tick_os,
    output logic              tick_bit,
    output logic              tick_mid,
    output logic              cfg_err
);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic [CNT_W-1:0]  act_int_q, act_int_d, pnd_int_q, pnd_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d, pnd_frac_q, pnd_frac_d;
    logic              pnd_vld_q, pnd_vld_d;
    logic              tick_os_q, tick_os_d, tick_bit_q, tick_bit_d, tick_mid_q, tick_mid_d;

    logic [FRAC_W:0]   sum;
    logic [CNT_W:0]    cnt_inc, per_len;
    logic              run, fire, apply;

    assign cfg_err  = act_int_q == '0;
    assign tick_os  = tick_os_q;
    assign tick_bit = tick_bit_q;
    assign tick_mid = tick_mid_q;

    always_comb begin
        // Carry of the phase accumulator stretches this period by one clock.
        sum        = {1'b0, acc_q} + {1'b0, act_frac_q};
        cnt_inc    = {1'b0, cnt_q} + 1'b1;
        per_len    = {1'b0, act_int_q} + {{CNT_W{1'b0}}, sum[FRAC_W]};
        run        = en && !cfg_err;
        fire       = !sync_clr && run && cnt_inc == per_len;
        // A load coinciding with a period end only becomes pending; the end uses the older pending value.
        apply      = (sync_clr || fire) && pnd_vld_q;
        cnt_d      = (sync_clr || fire) ? '0 : run ? cnt_inc[CNT_W-1:0] : cnt_q;
        acc_d      = sync_clr ? '0 : fire ? sum[FRAC_W-1:0] : acc_q;
        os_cnt_d   = sync_clr ? '0 : !fire ? os_cnt_q : os_cnt_q == OS_LAST ? '0 : os_cnt_q + 1'b1;
        tick_os_d  = fire;
        tick_bit_d = fire && os_cnt_q == OS_LAST;
        tick_mid_d = fire && os_cnt_q == OS_MID;
        act_int_d  = apply ? pnd_int_q : act_int_q;
        act_frac_d = apply ? pnd_frac_q : act_frac_q;
        pnd_int_d  = load ? div_int : pnd_int_q;
        pnd_frac_d = load ? div_frac : pnd_frac_q;
        pnd_vld_d  = load || (pnd_vld_q && !apply);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            os_cnt_q   <= '0;
            act_int_q  <= CNT_W'(1);
            act_frac_q <= '0;
            pnd_int_q  <= CNT_W'(1);
            pnd_frac_q <= '0;
            pnd_vld_q  <= 1'b0;
            tick_os_q  <= 1'b0;
            tick_bit_q <= 1'b0;
            tick_mid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            os_cnt_q   <= os_cnt_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            pnd_int_q  <= pnd_int_d;
            pnd_frac_q <= pnd_frac_d;
            pnd_vld_q  <= pnd_vld_d;
            tick_os_q  <= tick_os_d;
            tick_bit_q <= tick_bit_d;
            tick_mid_q <= tick_mid_d;
        end
    end
endmodule
